// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, instruction size, bubble word and
// the fetch FSM state encoding.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // All-zero word: decode treats it as a no-op.
    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0000;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Count on inc_i until all-ones, then hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction memory addressing and the
// IF_ID pipeline register, with stall/flush handling and event counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FS_IDLE | not fetching; PC holds, IF_ID carries a bubble
// FS_RUN  | fetching; flush redirects, stall holds, else PC advances
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = cpu_pkg::BUBBLE_INSTR,
    parameter int          CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      if_id_pc_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         run_edge;
    logic         stall_inc;
    logic         flush_inc;

    // A RUN edge with start_i low behaves like an IDLE edge, so it is excluded.
    assign run_edge  = (state_q == FS_RUN) && start_i;
    assign stall_inc = run_edge && stall_i && !flush_i;
    assign flush_inc = run_edge && flush_i;

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;

    // FSM, PC register and IF_ID register; flush beats stall beats sequential fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            if_id_pc_o    <= '0;
            if_id_instr_o <= BUBBLE_INSTR;
            if_id_valid_o <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if_id_pc_o    <= '0;
                    if_id_instr_o <= BUBBLE_INSTR;
                    if_id_valid_o <= 1'b0;
                    if (start_i) begin
                        state_q <= FS_RUN;
                    end
                end
                FS_RUN: begin
                    if (!start_i) begin
                        state_q       <= FS_IDLE;
                        if_id_pc_o    <= '0;
                        if_id_instr_o <= BUBBLE_INSTR;
                        if_id_valid_o <= 1'b0;
                    end else if (flush_i) begin
                        pc_q          <= branch_target_i & ~32'd3;
                        if_id_pc_o    <= '0;
                        if_id_instr_o <= BUBBLE_INSTR;
                        if_id_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        pc_q          <= pc_q + 32'(INSTR_BYTES);
                        if_id_pc_o    <= pc_q;
                        if_id_instr_o <= imem_data_i;
                        if_id_valid_o <= 1'b1;
                    end
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stimulus, checked
// against a cycle-level behavioural model. A second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] branch_target_i = '0;

    logic [31:0] imem_addr, imem_data, pc, if_id_pc, if_id_instr;
    logic        if_id_valid;
    logic [31:0] stall_cnt, flush_cnt;

    logic [31:0] s_imem_addr, s_imem_data, s_pc, s_if_id_pc, s_if_id_instr;
    logic        s_if_id_valid;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int failures = 0;

    // behavioural model
    logic        m_run;
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic        m_valid;
    longint      m_nstall, m_nflush;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    assign imem_data   = imem_word(imem_addr);
    assign s_imem_data = imem_word(s_imem_addr);

    fetch_stage u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_data),
        .pc_o            (pc),
        .if_id_pc_o      (if_id_pc),
        .if_id_instr_o   (if_id_instr),
        .if_id_valid_o   (if_id_valid),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    fetch_stage #(.CNT_W(2)) u_dut_sat (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (s_imem_addr),
        .imem_data_i     (s_imem_data),
        .pc_o            (s_pc),
        .if_id_pc_o      (s_if_id_pc),
        .if_id_instr_o   (s_if_id_instr),
        .if_id_valid_o   (s_if_id_valid),
        .stall_cnt_o     (s_stall_cnt),
        .flush_cnt_o     (s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input longint n, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return 32'(n > lim ? lim : n);
    endfunction

    task automatic model_reset();
        m_run    = 1'b0;
        m_pc     = 32'h0;
        m_ifpc   = 32'h0;
        m_instr  = 32'h0;
        m_valid  = 1'b0;
        m_nstall = 0;
        m_nflush = 0;
    endtask

    // One clock edge of the stage as seen from outside.
    task automatic model_edge();
        if (!m_run || !start_i) begin
            m_run   = start_i && !m_run ? 1'b1 : 1'b0;
            m_ifpc  = 32'h0;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (flush_i) begin
            m_pc    = {branch_target_i[31:2], 2'b00};
            m_ifpc  = 32'h0;
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_nflush++;
        end else if (stall_i) begin
            m_nstall++;
        end else begin
            m_ifpc  = m_pc;
            m_instr = imem_word(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_all();
        chk("pc",          pc,                 m_pc);
        chk("imem_addr",   imem_addr,          m_pc);
        chk("if_id_pc",    if_id_pc,           m_ifpc);
        chk("if_id_instr", if_id_instr,        m_instr);
        chk("if_id_valid", 32'(if_id_valid),   32'(m_valid));
        chk("stall_cnt",   stall_cnt,          sat(m_nstall, 32));
        chk("flush_cnt",   flush_cnt,          sat(m_nflush, 32));
        chk("sat_pc",      s_pc,               m_pc);
        chk("sat_stall",   32'(s_stall_cnt),   sat(m_nstall, 2));
        chk("sat_flush",   32'(s_flush_cnt),   sat(m_nflush, 2));
    endtask

    task automatic drive(input logic s, input logic st, input logic fl, input logic [31:0] tg);
        start_i         = s;
        stall_i         = st;
        flush_i         = fl;
        branch_target_i = tg;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
    endtask

    logic [31:0] hold_pc, hold_instr;
    logic [31:0] before_stall, before_flush;

    initial begin
        model_reset();
        #1;
        check_all();
        chk("rst_instr_bubble", if_id_instr, 32'h0);
        #2 rst_i = 1'b0;

        // start and sequential fetch
        drive(1, 0, 0, 0);
        step();                                   // edge 1: IDLE -> RUN
        step();                                   // edge 2: first fetch
        chk("t2_instr", if_id_instr, 32'h0050_0093);
        chk("t2_ifpc",  if_id_pc,    32'h0);
        chk("t2_pc",    pc,          32'h4);
        chk("t2_valid", 32'(if_id_valid), 32'h1);
        repeat (3) step();
        chk("t2_pc5",   pc,          32'h10);

        // stall two cycles at pc 0x08 with a real instruction in IF_ID
        drive(1, 0, 1, 32'h4);
        step();
        drive(1, 0, 0, 0);
        step();
        chk("t3_pc_pre", pc, 32'h8);
        hold_instr = if_id_instr;
        hold_pc    = if_id_pc;
        drive(1, 1, 0, 0);
        repeat (2) begin
            step();
            chk("t3_pc_hold",    pc,          32'h8);
            chk("t3_instr_hold", if_id_instr, hold_instr);
            chk("t3_ifpc_hold",  if_id_pc,    hold_pc);
        end
        chk("t3_stall_cnt", stall_cnt, 32'd2);
        drive(1, 0, 0, 0);
        step();
        chk("t3_pc_next", pc, 32'hC);

        // flush wins over stall, target gets aligned
        before_stall = stall_cnt;
        before_flush = flush_cnt;
        drive(1, 1, 1, 32'h23);
        step();
        chk("t4_pc",    pc,                32'h20);
        chk("t4_valid", 32'(if_id_valid),  32'h0);
        chk("t4_instr", if_id_instr,       32'h0);
        chk("t4_flush", flush_cnt,         before_flush + 32'd1);
        chk("t4_stall", stall_cnt,         before_stall);

        // PC wraps; small counters saturate
        drive(1, 0, 1, 32'hFFFF_FFFC);
        step();
        drive(1, 0, 0, 0);
        step();
        chk("t5_wrap_pc",   pc,       32'h0);
        chk("t5_wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0);
        repeat (5) step();
        chk("t5_sat_stall", 32'(s_stall_cnt), 32'd3);
        chk("t5_sat_flush", 32'(s_flush_cnt), 32'd3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) == 0, $urandom);
            step();
        end

        // start drop at pc 0x14, then resume there
        drive(1, 0, 0, 0);
        step();
        step();
        drive(1, 0, 1, 32'h10);
        step();
        drive(1, 0, 0, 0);
        step();
        chk("t6_pc_pre", pc, 32'h14);
        before_stall = stall_cnt;
        before_flush = flush_cnt;
        drive(0, 1, 0, 0);
        step();
        chk("t6_pc_hold", pc,               32'h14);
        chk("t6_valid",   32'(if_id_valid), 32'h0);
        chk("t6_stall",   stall_cnt,        before_stall);
        chk("t6_flush",   flush_cnt,        before_flush);
        drive(1, 0, 0, 0);
        step();
        step();
        chk("t6_resume_ifpc", if_id_pc, 32'h14);
        chk("t6_resume_pc",   pc,       32'h18);

        // asynchronous reset mid-run at pc 0x40
        drive(1, 0, 1, 32'h40);
        step();
        drive(1, 1, 0, 0);
        step();
        chk("t1_pc_pre", pc, 32'h40);
        #1 rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t1_valid", 32'(if_id_valid), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1, 0, 0, 0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
